// File: rtl/traffic_light_sequencer.sv
// Traffic-light phase sequencer: divides clk into a slow tick, dwells a
// programmable number of ticks per phase, and lets a pending pedestrian
// request cut GREEN short once the minimum green time has elapsed.
//
// state     | meaning
// ----------+----------------------------------------------
// GREEN  00 | traffic flowing, pedestrian request may shorten
// YELLOW1 01| amber after green, heading to RED
// YELLOW2 10| amber after red, heading to GREEN
// RED    11 | stop; safe state after reset
module traffic_light_sequencer #(
   parameter int DIV         = 50000000,
   parameter int T_GREEN     = 10,
   parameter int T_YELLOW    = 2,
   parameter int T_RED       = 8,
   parameter int T_MIN_GREEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   output logic [1:0] out_state,
   output logic       tick,
   output logic       ped_wait
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   localparam logic [1:0] ST_GREEN   = 2'b00;
   localparam logic [1:0] ST_YELLOW1 = 2'b01;
   localparam logic [1:0] ST_YELLOW2 = 2'b10;
   localparam logic [1:0] ST_RED     = 2'b11;

   localparam logic [7:0] MIN_GREEN_LAST = 8'(T_MIN_GREEN - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    dwell_q, dwell_d;
   logic [1:0]    state_q, state_d;
   logic          ped_wait_q, ped_wait_d;
   logic [7:0]    t_phase;
   logic [1:0]    state_next;

   // Tick is gated by reset so nothing downstream sees a pulse while held in reset
   assign tick = (presc_q == PRESC_MAX) && !rst;

   // Prescaler wraps at DIV-1; with DIV=1 it stays at 0 and ticks every cycle
   always_comb begin
      presc_d = presc_q + PW'(1);
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
      end
   end

   // Dwell length and successor for the current phase
   always_comb begin
      t_phase    = 8'(T_RED);
      state_next = ST_YELLOW2;
      case (state_q)
         ST_GREEN: begin
            t_phase    = 8'(T_GREEN);
            state_next = ST_YELLOW1;
         end
         ST_YELLOW1: begin
            t_phase    = 8'(T_YELLOW);
            state_next = ST_RED;
         end
         ST_YELLOW2: begin
            t_phase    = 8'(T_YELLOW);
            state_next = ST_GREEN;
         end
         default: begin
            t_phase    = 8'(T_RED);
            state_next = ST_YELLOW2;
         end
      endcase
   end

   // Phase advance on tick; early green end uses the registered request only,
   // so a request arriving on the same edge waits for the following tick
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      if (tick) begin
         if ((state_q == ST_GREEN) && ped_wait_q && (dwell_q >= MIN_GREEN_LAST)) begin
            state_d = ST_YELLOW1;
            dwell_d = 8'd0;
         end else if (dwell_q == (t_phase - 8'd1)) begin
            state_d = state_next;
            dwell_d = 8'd0;
         end else begin
            dwell_d = dwell_q + 8'd1;
         end
      end
   end

   // Pending request: RED entry serves it and wins over a simultaneous set
   always_comb begin
      ped_wait_d = ped_wait_q;
      if ((state_d == ST_RED) && (state_q != ST_RED)) begin
         ped_wait_d = 1'b0;
      end else if (ped_req && (state_q != ST_RED)) begin
         ped_wait_d = 1'b1;
      end
   end

   // State registers with synchronous reset into RED
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         dwell_q    <= 8'd0;
         state_q    <= ST_RED;
         ped_wait_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         dwell_q    <= dwell_d;
         state_q    <= state_d;
         ped_wait_q <= ped_wait_d;
      end
   end

   assign out_state = state_q;
   assign ped_wait  = ped_wait_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with DIV=4, T_GREEN=5,
// T_YELLOW=2, T_RED=3, T_MIN_GREEN=2. Phases are 12/8/20/8 cycles long.
module tb_traffic_light_sequencer;

   localparam logic [1:0] GREEN = 2'b00;
   localparam logic [1:0] Y1    = 2'b01;
   localparam logic [1:0] Y2    = 2'b10;
   localparam logic [1:0] RED   = 2'b11;

   logic       clk;
   logic       rst;
   logic       ped_req;
   logic [1:0] out_state;
   logic       tick;
   logic       ped_wait;

   int total;
   int bad;
   int cyc;
   logic hold;

   traffic_light_sequencer #(
      .DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_RED(3), .T_MIN_GREEN(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ped_req(ped_req),
      .out_state(out_state),
      .tick(tick),
      .ped_wait(ped_wait)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Check one phase for len cycles, optionally pulsing ped_req at offset poff
   task automatic expect_run(input logic [1:0] st, input int len, input int poff,
                             input int plen, input string tag);
      for (int i = 0; i < len; i++) begin
         ped_req = hold || ((i >= poff) && (i < poff + plen));
         chk({tag, "_state"}, 8'(out_state), 8'(st));
         chk({tag, "_tick"}, 8'(tick), 8'((cyc % 4) == 3));
         step();
      end
      ped_req = hold;
   endtask

   initial begin
      clk     = 1'b0;
      rst     = 1'b1;
      ped_req = 1'b0;
      hold    = 1'b0;
      total   = 0;
      bad     = 0;
      cyc     = 0;

      step();
      chk("rst_tick", 8'(tick), 8'd0);
      chk("rst_state", 8'(out_state), 8'(RED));
      chk("rst_pw", 8'(ped_wait), 8'd0);
      step();
      chk("rst_tick2", 8'(tick), 8'd0);
      rst = 1'b0;
      cyc = 0;

      // Free run, three full 48-cycle periods
      for (int p = 0; p < 3; p++) begin
         expect_run(RED, 12, -1, 0, "free_red");
         expect_run(Y2, 8, -1, 0, "free_y2");
         expect_run(GREEN, 20, -1, 0, "free_green");
         chk("free_pw", 8'(ped_wait), 8'd0);
         expect_run(Y1, 8, -1, 0, "free_y1");
      end

      // Request in first GREEN cycle: GREEN shortened to 8 cycles
      expect_run(RED, 12, -1, 0, "a_red");
      expect_run(Y2, 8, -1, 0, "a_y2");
      expect_run(GREEN, 1, 0, 1, "a_green0");
      chk("a_pw_set", 8'(ped_wait), 8'd1);
      expect_run(GREEN, 7, -1, 0, "a_green");
      expect_run(Y1, 8, -1, 0, "a_y1");
      chk("a_pw_clr", 8'(ped_wait), 8'd0);

      // Request after the 4th green tick: GREEN stays 20 cycles
      expect_run(RED, 12, -1, 0, "b_red");
      expect_run(Y2, 8, -1, 0, "b_y2");
      expect_run(GREEN, 20, 16, 1, "b_green");
      chk("b_pw_y1", 8'(ped_wait), 8'd1);
      expect_run(Y1, 8, -1, 0, "b_y1");
      chk("b_pw_clr", 8'(ped_wait), 8'd0);

      // Request during RED is ignored
      expect_run(RED, 12, 4, 1, "c_red");
      chk("c_pw", 8'(ped_wait), 8'd0);
      expect_run(Y2, 8, -1, 0, "c_y2");
      expect_run(GREEN, 20, -1, 0, "c_green");
      expect_run(Y1, 8, -1, 0, "c_y1");

      // Request during YELLOW1 is served at RED entry; next GREEN full length
      expect_run(RED, 12, -1, 0, "d_red");
      expect_run(Y2, 8, -1, 0, "d_y2");
      expect_run(GREEN, 20, -1, 0, "d_green");
      expect_run(Y1, 3, 2, 1, "d_y1a");
      chk("d_pw_set", 8'(ped_wait), 8'd1);
      expect_run(Y1, 5, -1, 0, "d_y1b");
      chk("d_pw_clr", 8'(ped_wait), 8'd0);
      expect_run(RED, 12, -1, 0, "d_red2");
      expect_run(Y2, 8, -1, 0, "d_y2b");
      expect_run(GREEN, 20, -1, 0, "d_green2");
      expect_run(Y1, 8, -1, 0, "d_y1c");

      // Request held high: every GREEN is 8 cycles
      hold = 1'b1;
      for (int p = 0; p < 2; p++) begin
         expect_run(RED, 12, -1, 0, "e_red");
         chk("e_pw_red", 8'(ped_wait), 8'd0);
         expect_run(Y2, 1, -1, 0, "e_y2a");
         chk("e_pw_y2", 8'(ped_wait), 8'd1);
         expect_run(Y2, 7, -1, 0, "e_y2b");
         expect_run(GREEN, 8, -1, 0, "e_green");
         expect_run(Y1, 8, -1, 0, "e_y1");
         chk("e_pw_clr", 8'(ped_wait), 8'd0);
      end
      hold = 1'b0;
      ped_req = 1'b0;

      // Reset pulsed mid-GREEN, on a cycle where tick would otherwise fire
      expect_run(RED, 12, -1, 0, "f_red");
      expect_run(Y2, 8, -1, 0, "f_y2");
      expect_run(GREEN, 7, 0, 1, "f_green");
      chk("f_pw_pre", 8'(ped_wait), 8'd1);
      rst = 1'b1;
      #1;
      chk("f_rst_tick", 8'(tick), 8'd0);
      step();
      rst = 1'b0;
      cyc = 0;
      chk("f_state", 8'(out_state), 8'(RED));
      chk("f_pw", 8'(ped_wait), 8'd0);
      expect_run(RED, 12, -1, 0, "f_red2");
      expect_run(Y2, 8, -1, 0, "f_y2b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so a stuck run still terminates
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
